// File: rtl/param_alu_pipeline_pkg.sv
// Shared definitions for the param_alu_pipeline core.
//   - instruction field positions (op[31:26] rd[25:21] rs[20:16] rt[15:11] imm[15:0])
//   - opcode encodings
//   - op_is_illegal : opcode legality decode
//   - op_uses_rt    : whether an opcode reads the rt register
//   - alu_compute   : ALU result on ALU_W-bit sign-extended operands; callers
//                     truncate to their datapath width, which keeps modular
//                     arithmetic and signed compares exact for DATA_W <= ALU_W.
package param_alu_pipeline_pkg;

    localparam int INSTR_W = 32;
    localparam int OP_LSB  = 26;
    localparam int OP_W    = 6;
    localparam int RD_LSB  = 21;
    localparam int RS_LSB  = 16;
    localparam int RT_LSB  = 11;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 16;
    localparam int ALU_W   = 64;

    typedef logic [OP_W-1:0]         opcode_t;
    typedef logic signed [ALU_W-1:0] alu_word_t;

    localparam opcode_t OP_MOV  = 6'h00;
    localparam opcode_t OP_NOT  = 6'h01;
    localparam opcode_t OP_AND  = 6'h02;
    localparam opcode_t OP_ADD  = 6'h03;
    localparam opcode_t OP_NOR  = 6'h04;
    localparam opcode_t OP_NAND = 6'h05;
    localparam opcode_t OP_SUB  = 6'h06;
    localparam opcode_t OP_SLT  = 6'h07;
    localparam opcode_t OP_OR   = 6'h08;
    localparam opcode_t OP_XOR  = 6'h09;
    localparam opcode_t OP_ADDI = 6'h0B;
    localparam opcode_t OP_SUBI = 6'h0E;

    function automatic logic op_is_illegal(input opcode_t op);
        case (op)
            OP_MOV, OP_NOT, OP_AND, OP_ADD, OP_NOR, OP_NAND, OP_SUB,
            OP_SLT, OP_OR, OP_XOR, OP_ADDI, OP_SUBI: return 1'b0;
            default:                                 return 1'b1;
        endcase
    endfunction

    function automatic logic op_uses_rt(input opcode_t op);
        case (op)
            OP_AND, OP_ADD, OP_NOR, OP_NAND, OP_SUB,
            OP_SLT, OP_OR, OP_XOR: return 1'b1;
            default:               return 1'b0;
        endcase
    endfunction

    function automatic alu_word_t alu_compute(input opcode_t op, input alu_word_t a,
                                              input alu_word_t b, input alu_word_t imm);
        case (op)
            OP_MOV:  return a;
            OP_NOT:  return ~a;
            OP_AND:  return a & b;
            OP_ADD:  return a + b;
            OP_NOR:  return ~(a | b);
            OP_NAND: return ~(a & b);
            OP_SUB:  return a - b;
            OP_SLT:  return {{(ALU_W-1){1'b0}}, (a < b)};
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_ADDI: return a + imm;
            OP_SUBI: return a - imm;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/param_alu_regfile.sv
// Register file for param_alu_pipeline.
//   NUM_REGS x DATA_W, cleared by asynchronous active-low reset.
//   Two asynchronous read ports; reads return the array, so a write at an
//   edge is visible to readers throughout the following cycle.
//   One write path per register, fed by a priority mux: the pipeline
//   write-back (wb_*) wins over the preload port (cfg_*) on the same index.
// Ports:
//   clk, rst_n                     clock / async active-low reset
//   cfg_we, cfg_addr, cfg_wdata    preload write
//   wb_we, wb_addr, wb_wdata       pipeline write-back
//   rd_addr_a/b, rd_data_a/b       read ports
module param_alu_regfile
    import param_alu_pipeline_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int IDX_W    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    input  logic              wb_we,
    input  logic [IDX_W-1:0]  wb_addr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic [IDX_W-1:0]  rd_addr_a,
    input  logic [IDX_W-1:0]  rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wb_we && (wb_addr == IDX_W'(i))) begin
                    regs[i] <= wb_wdata;
                end else if (cfg_we && (cfg_addr == IDX_W'(i))) begin
                    regs[i] <= cfg_wdata;
                end
            end
        end
    end

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/param_alu_pipeline.sv
// param_alu_pipeline: 3-stage (ID / EX / WB) register-to-register ALU core.
//   An instruction accepted at edge k sits in ID during cycle k, is in EX
//   during cycle k+1, and at edge k+2 writes rd and updates out_*.
//   Illegal opcodes flow through with out_err=1, out_result=0, no write.
// Build option (macro FORWARDING_EN):
//   defined   - the EX result is bypassed into the ID operands; never stalls.
//   undefined - an ID instruction reading the EX destination is held in ID
//               for one cycle (in_ready=0) and a bubble enters EX.
// Ports:
//   clk, rst_n             clock / async active-low reset
//   in_valid, in_ready     instruction handshake
//   instr                  op[31:26] rd[25:21] rs[20:16] rt[15:11] imm[15:0]
//   cfg_we/addr/wdata      register preload (pipeline must be empty)
//   out_valid              one-cycle pulse per retired instruction
//   out_result, out_err    result / illegal-opcode flag of retired instr
//   retired_cnt            retired-instruction count, wraps
// Supports DATA_W from 8 to 64.
module param_alu_pipeline
    import param_alu_pipeline_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic              cfg_we,
    input  logic [4:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic              out_err,
    output logic [CNT_W-1:0]  retired_cnt
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                     id_valid;
    logic [INSTR_W-1:0]       id_instr;
    opcode_t                  id_op;
    logic [IDX_W-1:0]         id_rd;
    logic [IDX_W-1:0]         id_rs;
    logic [IDX_W-1:0]         id_rt;
    logic signed [DATA_W-1:0] rf_a;
    logic signed [DATA_W-1:0] rf_b;
    logic signed [DATA_W-1:0] id_a;
    logic signed [DATA_W-1:0] id_b;
    logic                     id_issue;
    logic                     rs_hit;
    logic                     rt_hit;

    logic                     ex_valid;
    logic                     ex_err;
    opcode_t                  ex_op;
    logic [IDX_W-1:0]         ex_rd;
    logic signed [DATA_W-1:0] ex_a;
    logic signed [DATA_W-1:0] ex_b;
    logic signed [IMM_W-1:0]  ex_imm;
    logic signed [DATA_W-1:0] ex_result;
    logic                     ex_writes;

    // ---- ID stage: decode and register read ----
    assign id_op = id_instr[OP_LSB +: OP_W];
    assign id_rd = id_instr[RD_LSB +: IDX_W];
    assign id_rs = id_instr[RS_LSB +: IDX_W];
    assign id_rt = id_instr[RT_LSB +: IDX_W];

    param_alu_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr[IDX_W-1:0]),
        .cfg_wdata (cfg_wdata),
        .wb_we     (ex_writes),
        .wb_addr   (ex_rd),
        .wb_wdata  (ex_result),
        .rd_addr_a (id_rs),
        .rd_addr_b (id_rt),
        .rd_data_a (rf_a),
        .rd_data_b (rf_b)
    );

    // Only a valid, legal EX instruction produces a register value that a
    // younger instruction could depend on.
    assign ex_writes = ex_valid && !ex_err;
    assign rs_hit    = ex_writes && (id_rs == ex_rd);
    assign rt_hit    = ex_writes && op_uses_rt(id_op) && (id_rt == ex_rd);

`ifdef FORWARDING_EN
    assign id_a     = rs_hit ? ex_result : rf_a;
    assign id_b     = rt_hit ? ex_result : rf_b;
    assign in_ready = 1'b1;
`else
    // Holding ID for one cycle lets the EX result land in the regfile; the
    // following cycle EX holds a bubble, so the stall never exceeds 1 cycle.
    assign id_a     = rf_a;
    assign id_b     = rf_b;
    assign in_ready = !(id_valid && !op_is_illegal(id_op) && (rs_hit || rt_hit));
`endif

    assign id_issue = id_valid && in_ready;

    // ---- EX stage: ALU ----
    assign ex_result = DATA_W'(alu_compute(ex_op, alu_word_t'(ex_a), alu_word_t'(ex_b),
                                           alu_word_t'(ex_imm)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid    <= 1'b0;
            ex_valid    <= 1'b0;
            out_valid   <= 1'b0;
            out_err     <= 1'b0;
            out_result  <= '0;
            retired_cnt <= '0;
        end else begin
            if (in_ready) begin
                id_valid <= in_valid;
            end
            ex_valid  <= id_issue;
            // ---- WB stage: retire ----
            out_valid <= ex_valid;
            out_err   <= ex_valid && ex_err;
            if (ex_valid) begin
                out_result  <= ex_err ? '0 : ex_result;
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end

    // Payload registers are qualified by id_valid / ex_valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            id_instr <= instr;
        end
        if (id_issue) begin
            ex_op  <= id_op;
            ex_err <= op_is_illegal(id_op);
            ex_rd  <= id_rd;
            ex_a   <= id_a;
            ex_b   <= id_b;
            ex_imm <= id_instr[IMM_LSB +: IMM_W];
        end
    end

endmodule
